// File: rtl/srio_lane_sync.sv
// RapidIO per-lane sync monitor: comma acquisition, error tolerance, loss of sync.
// Define SRIO_LANE_SYNC_STATS_EN to add sync_loss_cnt and comma_seen.
//
// state    | meaning
// NO_SYNC  | acquiring: counting valid K28.5 commas
// SYNC     | lane synchronised, error level 0
// SYNC_ERR | synchronised with error level 1..ERR_MAX-1, tracking clean characters
module srio_lane_sync #(
   parameter int COMMA_THRESH = 127,
   parameter int GOOD_THRESH  = 256,
   parameter int ERR_MAX      = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [15:0] rx_data,
   input  logic [1:0]  rx_charisk,
   input  logic [1:0]  rx_disperr,
   input  logic [1:0]  rx_notintable,
   input  logic        err_clr,
   output logic        lane_sync,
   output logic        sync_lost,
   output logic [2:0]  err_level,
   output logic [15:0] err_cnt
`ifdef SRIO_LANE_SYNC_STATS_EN
   ,
   output logic [7:0]  sync_loss_cnt,
   output logic        comma_seen
`endif
);

   typedef enum logic [1:0] {
      NO_SYNC  = 2'd0,
      SYNC     = 2'd1,
      SYNC_ERR = 2'd2
   } state_t;

   localparam logic [8:0]  COMMA_T = 9'(COMMA_THRESH);
   localparam logic [10:0] GOOD_T  = 11'(GOOD_THRESH);
   localparam logic [3:0]  EMAX_W  = 4'(ERR_MAX);
   localparam logic [2:0]  EMAX    = 3'(ERR_MAX);

   state_t      state;
   logic [8:0]  comma_cnt;
   logic [10:0] good_cnt;

   logic        inv0, inv1, com0, com1;
   logic [1:0]  n_inv, n_com;
   logic [8:0]  comma_sum;
   logic        comma_hit;
   logic [10:0] good_sum;
   logic        good_hit;
   logic [2:0]  lvl_base;
   logic [3:0]  lvl_sum;
   logic [2:0]  lvl_new;
   logic        lvl_lose;
   logic        lose_evt;
   logic [16:0] err_sum;

   always_comb begin
      inv0      = rx_disperr[0] | rx_notintable[0];
      inv1      = rx_disperr[1] | rx_notintable[1];
      com0      = rx_charisk[0] & (rx_data[7:0] == 8'hBC) & ~inv0;
      com1      = rx_charisk[1] & (rx_data[15:8] == 8'hBC) & ~inv1;
      n_inv     = {1'b0, inv0} + {1'b0, inv1};
      n_com     = {1'b0, com0} + {1'b0, com1};
      comma_sum = comma_cnt + {7'd0, n_com};
      comma_hit = (comma_sum >= COMMA_T);
      good_sum  = good_cnt + 11'd2;
      good_hit  = (good_sum >= GOOD_T);
      // From SYNC the new level starts at zero, so the same adder yields min(n_inv, ERR_MAX)
      lvl_base  = (state == SYNC_ERR) ? err_level : 3'd0;
      lvl_sum   = {1'b0, lvl_base} + {2'b00, n_inv};
      lvl_lose  = (lvl_sum >= EMAX_W);
      lvl_new   = lvl_lose ? EMAX : lvl_sum[2:0];
      lose_evt  = rx_valid & (state != NO_SYNC) & (n_inv != 2'd0) & lvl_lose;
      err_sum   = {1'b0, err_cnt} + {15'd0, n_inv};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= NO_SYNC;
         comma_cnt <= '0;
         good_cnt  <= '0;
         err_level <= '0;
         lane_sync <= 1'b0;
         sync_lost <= 1'b0;
      end else begin
         sync_lost <= 1'b0;
         if (rx_valid) begin
            case (state)
               NO_SYNC: begin
                  if (n_inv != 2'd0) begin
                     comma_cnt <= '0;
                  end else if (comma_hit) begin
                     state     <= SYNC;
                     comma_cnt <= '0;
                     lane_sync <= 1'b1;
                  end else begin
                     comma_cnt <= comma_sum;
                  end
               end
               SYNC, SYNC_ERR: begin
                  if (n_inv != 2'd0) begin
                     good_cnt <= '0;
                     if (lvl_lose) begin
                        state     <= NO_SYNC;
                        err_level <= '0;
                        comma_cnt <= '0;
                        lane_sync <= 1'b0;
                        sync_lost <= 1'b1;
                     end else begin
                        state     <= SYNC_ERR;
                        err_level <= lvl_new;
                     end
                  end else if (state == SYNC_ERR) begin
                     if (good_hit) begin
                        good_cnt  <= '0;
                        err_level <= err_level - 3'd1;
                        if (err_level == 3'd1)
                           state <= SYNC;
                     end else begin
                        good_cnt <= good_sum;
                     end
                  end
               end
               default: begin
                  state     <= NO_SYNC;
                  lane_sync <= 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_cnt <= '0;
      else if (err_clr)
         err_cnt <= '0;
      else if (rx_valid)
         err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

`ifdef SRIO_LANE_SYNC_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_loss_cnt <= '0;
         comma_seen    <= 1'b0;
      end else if (err_clr) begin
         sync_loss_cnt <= '0;
         comma_seen    <= 1'b0;
      end else begin
         if (lose_evt && (sync_loss_cnt != 8'hFF))
            sync_loss_cnt <= sync_loss_cnt + 8'd1;
         if (rx_valid && (com0 || com1))
            comma_seen <= 1'b1;
      end
   end
`else
   logic unused_lose;
   assign unused_lose = lose_evt;
`endif

endmodule

// File: tb/tb_srio_lane_sync.sv
// Scoreboard bench for srio_lane_sync: driver queues hand-computed expectations,
// a negedge monitor pops and compares them one cycle after each word.
module tb_srio_lane_sync;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0;
   logic [15:0] rx_data = '0;
   logic [1:0]  rx_charisk = '0;
   logic [1:0]  rx_disperr = '0;
   logic [1:0]  rx_notintable = '0;
   logic        err_clr = 1'b0;
   logic        lane_sync;
   logic        sync_lost;
   logic [2:0]  err_level;
   logic [15:0] err_cnt;
`ifdef SRIO_LANE_SYNC_STATS_EN
   logic [7:0]  sync_loss_cnt;
   logic        comma_seen;
`endif

   srio_lane_sync dut (
      .clk           (clk),
      .rst           (rst),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_charisk    (rx_charisk),
      .rx_disperr    (rx_disperr),
      .rx_notintable (rx_notintable),
      .err_clr       (err_clr),
      .lane_sync     (lane_sync),
      .sync_lost     (sync_lost),
      .err_level     (err_level),
      .err_cnt       (err_cnt)
`ifdef SRIO_LANE_SYNC_STATS_EN
      ,
      .sync_loss_cnt (sync_loss_cnt),
      .comma_seen    (comma_seen)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        ls;
      logic        sl;
      logic [2:0]  lvl;
      logic [15:0] cnt;
      logic [7:0]  sid;
      logic [15:0] vid;
   } exp_t;

   exp_t        q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic        e_ls = 1'b0;
   logic        e_sl = 1'b0;
   logic [2:0]  e_lvl = '0;
   logic [15:0] e_cnt = '0;
   int          sid = 0;
   int          vid = 0;

   task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] k,
                        input logic [1:0] de, input logic [1:0] ni, input logic clr);
      exp_t e;
      @(negedge clk);
      rx_valid      = v;
      rx_data       = d;
      rx_charisk    = k;
      rx_disperr    = de;
      rx_notintable = ni;
      err_clr       = clr;
      @(posedge clk);
      e.ls  = e_ls;
      e.sl  = e_sl;
      e.lvl = e_lvl;
      e.cnt = e_cnt;
      e.sid = 8'(sid);
      e.vid = 16'(vid);
      vid++;
      q.push_back(e);
   endtask

   task automatic comma_word();
      drive(1'b1, 16'hBCBC, 2'b11, 2'b00, 2'b00, 1'b0);
   endtask

   task automatic clean_word();
      drive(1'b1, 16'h1234, 2'b00, 2'b00, 2'b00, 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         vectors++;
         if (lane_sync !== e.ls || sync_lost !== e.sl || err_level !== e.lvl || err_cnt !== e.cnt) begin
            miscompares++;
            $display("FAIL s%0d v%0d outputs: got ls=%0b sl=%0b lvl=%0d cnt=%h, want ls=%0b sl=%0b lvl=%0d cnt=%h",
                     e.sid, e.vid, lane_sync, sync_lost, err_level, err_cnt, e.ls, e.sl, e.lvl, e.cnt);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // reset state observed through an idle cycle
      sid = 0;
      drive(1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);

      // acquisition: 64 double-comma words, sync only after the 64th
      sid = 1;
      for (int i = 0; i < 64; i++) begin
         e_ls = (i == 63);
         comma_word();
      end

      // error recovery: one notintable byte, then 128 clean words
      sid = 3;
      e_ls = 1'b1; e_lvl = 3'd1; e_cnt = 16'd1;
      drive(1'b1, 16'hBCBC, 2'b11, 2'b00, 2'b01, 1'b0);
      for (int k = 1; k <= 128; k++) begin
         e_lvl = (k == 128) ? 3'd0 : 3'd1;
         clean_word();
      end

      // loss of sync: clear counter, two-byte disparity error, clean, one more invalid
      sid = 4;
      e_cnt = 16'd0;
      drive(1'b1, 16'h1234, 2'b00, 2'b00, 2'b00, 1'b1);
      e_lvl = 3'd2; e_cnt = 16'd2;
      drive(1'b1, 16'hBCBC, 2'b11, 2'b11, 2'b00, 1'b0);
      clean_word();
      e_ls = 1'b0; e_sl = 1'b1; e_lvl = 3'd0; e_cnt = 16'd3;
      drive(1'b1, 16'h1234, 2'b00, 2'b00, 2'b10, 1'b0);
      e_sl = 1'b0;
      drive(1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);

      // invalid byte during acquisition restarts the comma count
      sid = 2;
      for (int i = 0; i < 40; i++) comma_word();
      e_cnt = 16'd4;
      drive(1'b1, 16'hBCBC, 2'b11, 2'b01, 2'b00, 1'b0);
      for (int i = 0; i < 64; i++) begin
         e_ls = (i == 63);
         comma_word();
      end

      // rx_valid gating in SYNC_ERR, then asynchronous reset
      sid = 6;
      e_ls = 1'b1; e_lvl = 3'd1; e_cnt = 16'd5;
      drive(1'b1, 16'hBCBC, 2'b11, 2'b00, 2'b01, 1'b0);
      for (int i = 0; i < 3; i++)
         drive(1'b0, 16'hFFFF, 2'b00, 2'b11, 2'b11, 1'b0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      vectors++;
      if (lane_sync !== 1'b0 || sync_lost !== 1'b0 || err_level !== 3'd0 || err_cnt !== 16'd0) begin
         miscompares++;
         $display("FAIL async_rst: got ls=%0b sl=%0b lvl=%0d cnt=%h, want all zero",
                  lane_sync, sync_lost, err_level, err_cnt);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      e_ls = 1'b0; e_sl = 1'b0; e_lvl = 3'd0; e_cnt = 16'd0;

      // saturation of err_cnt, then err_clr beating a simultaneous invalid word
      sid = 5;
      for (int k = 1; k <= 40000; k++) begin
         e_cnt = (2 * k > 65535) ? 16'hFFFF : 16'(2 * k);
         drive(1'b1, 16'h0000, 2'b00, 2'b11, 2'b11, 1'b0);
      end
      e_cnt = 16'd0;
      drive(1'b1, 16'h0000, 2'b00, 2'b11, 2'b11, 1'b1);
      e_cnt = 16'd2;
      drive(1'b1, 16'h0000, 2'b00, 2'b11, 2'b00, 1'b0);

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
